// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller: register map,
// trigger-mode encoding and a lowest-set-bit priority encoder.
package irq_ctrl_pkg;

    localparam int unsigned MAX_CHAN = 8;

    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_MODE = 3'd2;
    localparam logic [2:0] REG_ISR  = 3'd3;
    localparam logic [2:0] REG_OVF  = 3'd4;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_LEVEL  = 1'b1;

    // Index of the lowest set bit; 0 when v is all zero (qualify with |v).
    function automatic logic [2:0] lsb_index(input logic [MAX_CHAN-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = int'(MAX_CHAN) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// One IRQ channel front end: two-flop synchroniser, previous-sample register,
// toggle-event and level outputs. Reset preloads every stage from the live line.
module irq_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_irq,
    output logic o_event_c,
    output logic o_level
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Preloading on reset keeps a line that is already high from looking like an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= i_irq;
            r_sync2 <= i_irq;
            r_prev  <= i_irq;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_event_c = r_sync2 ^ r_prev;
    assign o_level   = r_sync2;

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority nesting interrupt controller with per-channel mask, trigger
// mode, pending/in-service/overflow tracking and a CPU ack/EOI handshake.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NCHAN      = 8,
    parameter logic [15:0] VEC_BASE   = 16'h0002,
    parameter int unsigned VEC_STRIDE = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [NCHAN-1:0] IRQ,
    input  logic [2:0]       I_ADDR,
    input  logic [7:0]       I_DATA,
    input  logic             I_WREN,
    output logic [7:0]       O_DATA,
    input  logic             I_IE,
    output logic             O_REQ,
    output logic [15:0]      O_VEC,
    input  logic             I_ACK,
    input  logic             I_EOI
);

    logic [NCHAN-1:0] r_pend;
    logic [NCHAN-1:0] r_mask;
    logic [NCHAN-1:0] r_mode;
    logic [NCHAN-1:0] r_isr;
    logic [NCHAN-1:0] r_ovf;

    logic [NCHAN-1:0] w_event;
    logic [NCHAN-1:0] w_level;

    logic [NCHAN-1:0] w_wdata;
    logic             w_wr_pend;
    logic             w_wr_mask;
    logic             w_wr_mode;
    logic             w_wr_ovf;

    logic [NCHAN-1:0] w_cand;
    logic [NCHAN-1:0] w_allow;
    logic [NCHAN-1:0] w_sel;
    logic             w_isr_any;
    logic [2:0]       w_isr_idx;
    logic             w_win_valid;
    logic [2:0]       w_win_idx;
    logic [NCHAN-1:0] w_win_oh;
    logic             w_ack_fire;
    logic [NCHAN-1:0] w_ack_oh;
    logic [NCHAN-1:0] w_isr_low;
    logic [NCHAN-1:0] w_eoi_clr;

    logic [NCHAN-1:0] w_mode_nxt;
    logic [NCHAN-1:0] w_mask_nxt;
    logic [NCHAN-1:0] w_pend_clr;
    logic [NCHAN-1:0] w_ovf_clr;
    logic [NCHAN-1:0] w_pend_nxt;
    logic [NCHAN-1:0] w_ovf_nxt;
    logic [NCHAN-1:0] w_isr_nxt;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        irq_sync_edge u_sync (
            .i_clk     (CLOCK),
            .i_rst     (RESET),
            .i_irq     (IRQ[g]),
            .o_event_c (w_event[g]),
            .o_level   (w_level[g])
        );
    end

    assign w_wdata   = I_DATA[NCHAN-1:0];
    assign w_wr_pend = I_WREN && (I_ADDR == REG_PEND);
    assign w_wr_mask = I_WREN && (I_ADDR == REG_MASK);
    assign w_wr_mode = I_WREN && (I_ADDR == REG_MODE);
    assign w_wr_ovf  = I_WREN && (I_ADDR == REG_OVF);

    // Winner: lowest candidate strictly above (lower index than) the active nesting level.
    always_comb begin
        w_cand    = r_pend & r_mask & ~r_isr;
        w_isr_any = |r_isr;
        w_isr_idx = lsb_index(MAX_CHAN'(r_isr));
        w_allow   = '0;
        for (int k = 0; k < int'(NCHAN); k++) begin
            w_allow[k] = !w_isr_any || (4'(k) < {1'b0, w_isr_idx});
        end
        w_sel       = w_cand & w_allow;
        w_win_valid = |w_sel;
        w_win_idx   = lsb_index(MAX_CHAN'(w_sel));
        w_win_oh    = NCHAN'(1) << w_win_idx;
    end

    assign O_REQ      = I_IE & w_win_valid;
    assign O_VEC      = w_win_valid ? (VEC_BASE + 16'(w_win_idx) * 16'(VEC_STRIDE)) : 16'h0000;
    assign w_ack_fire = I_ACK & O_REQ;
    assign w_ack_oh   = w_ack_fire ? w_win_oh : '0;
    assign w_isr_low  = r_isr & (~r_isr + NCHAN'(1));
    assign w_eoi_clr  = I_EOI ? w_isr_low : '0;

    // Next-state for the configuration and status registers.
    always_comb begin
        w_mode_nxt = w_wr_mode ? w_wdata : r_mode;
        w_mask_nxt = w_wr_mask ? w_wdata : r_mask;
        w_pend_clr = w_wr_pend ? w_wdata : '0;
        w_ovf_clr  = w_wr_ovf  ? w_wdata : '0;
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf & ~w_ovf_clr;
        for (int k = 0; k < int'(NCHAN); k++) begin
            if (w_mode_nxt[k] == MODE_LEVEL) begin
                w_pend_nxt[k] = w_level[k];
            end else if (r_mode[k] == MODE_LEVEL) begin
                w_pend_nxt[k] = 1'b0;
            end else begin
                // A fresh edge outranks both software clear and acknowledge.
                w_pend_nxt[k] = w_event[k] | (r_pend[k] & ~w_pend_clr[k] & ~w_ack_oh[k]);
                w_ovf_nxt[k]  = w_ovf_nxt[k] | (w_event[k] & r_pend[k]);
            end
        end
        w_isr_nxt = (r_isr & ~w_eoi_clr) | w_ack_oh;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pend <= '0;
            r_mask <= '0;
            r_mode <= '0;
            r_isr  <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_mask <= w_mask_nxt;
            r_mode <= w_mode_nxt;
            r_isr  <= w_isr_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    always_comb begin
        O_DATA = 8'h00;
        case (I_ADDR)
            REG_PEND: O_DATA = 8'(r_pend);
            REG_MASK: O_DATA = 8'(r_mask);
            REG_MODE: O_DATA = 8'(r_mode);
            REG_ISR:  O_DATA = 8'(r_isr);
            REG_OVF:  O_DATA = 8'(r_ovf);
            default:  O_DATA = 8'h00;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller for the 8-bit-bus CPU family; it generalises the three fixed toggle-triggered IRQ lines into NCHAN channels.
- Per-channel features: mask, trigger mode (toggle or level), pending and in-service tracking.
- Uses fixed priority with nesting, and provides a request/acknowledge/EOI handshake to the CPU core.
- Sits between peripherals (keyboard, mouse, timer, …) and the CPU; its configuration registers are mapped on the CPU data bus.

Parameters:
- NCHAN, 8, number of IRQ channels (1..8); channel 0 has the highest priority.
- VEC_BASE, 16'h0002, vector address of channel 0.
- VEC_STRIDE, 2, byte distance between consecutive channel vectors.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous reset, active-high
- IRQ  in  NCHAN  peripheral request lines, asynchronous to CLOCK
- I_ADDR  in  3  register select
- I_DATA  in  8  register write data
- I_WREN  in  1  register write strobe, sampled on the CLOCK edge
- O_DATA  out  8  register read data, combinational from I_ADDR
- I_IE  in  1  CPU interrupt-enable flag
- O_REQ  out  1  interrupt request to the CPU
- O_VEC  out  16  vector of the current winning channel
- I_ACK  in  1  one-cycle acknowledge from the CPU
- I_EOI  in  1  one-cycle end-of-interrupt pulse (CPU RETI)

Behaviour:
- Registers (unused bits [7:NCHAN] read 0, writes to them ignored):
  - 0 PEND: read; write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 MODE: read/write; 0 = toggle, 1 = level-high.
  - 3 ISR: read-only.
  - 4 OVF: read; write-1-to-clear.
  - Addresses 5..7 read 0; writes ignored.
- Reset:
  - PEND, MASK, MODE, ISR and OVF are cleared.
  - Both synchroniser stages and the previous-sample register load the current IRQ value, so an already-high line gives no spurious event on release.
  - O_REQ=0 the cycle after reset.
  - Reset mid-handshake drops all state; no ACK is remembered.
- Input path, per channel:
  - 2-flop synchroniser, then a previous-sample register.
  - Toggle event: sync2 != prev.
  - Level state: sync2.
- Pending:
  - Toggle mode: PEND[k] is set on an event.
    - An event while PEND[k]=1 sets OVF[k] (events are merged).
    - Latency: an IRQ change settled before edge E gives PEND[k]=1 after edge E+2.
  - Level mode: PEND[k] follows sync2 each cycle; W1C and ACK have no lasting effect.
  - Same-cycle precedence:
    - A new event beats a W1C clear of the same bit.
    - A new event beats an ACK clear of the same bit; pending stays 1.
- Winner selection (combinational from registers):
  - cand = PEND & MASK & ~ISR.
  - win = the lowest-index cand bit whose index is below the lowest set ISR bit (all indices allowed if ISR=0).
  - O_REQ = I_IE & win valid.
  - O_VEC = VEC_BASE + win*VEC_STRIDE, 16-bit, wrapping modulo 2^16; it holds 0 when there is no winner.
- Acknowledge:
  - I_ACK at an edge with O_REQ=1 clears PEND[win] (toggle mode only) and sets ISR[win].
  - The CPU captures O_VEC in the same cycle it asserts I_ACK.
  - I_ACK with O_REQ=0 is ignored.
- End of interrupt:
  - I_EOI clears the lowest set ISR bit.
  - I_EOI with ISR=0 has no effect.
  - ACK and EOI in the same cycle:
    - EOI acts on the pre-edge ISR and ACK sets its bit.
    - If they hit the same bit, the result is set.
- Masking: changing MASK never alters PEND or ISR. A masked pending bit requests once it is unmasked.
- Mode change:
  - A write of MODE toggle→level reloads PEND[k] from sync2.
  - A write of MODE level→toggle clears PEND[k].

Decomposition:
- Package irq_ctrl_pkg holds:
  - register address constants (REG_PEND=0 … REG_OVF=4);
  - MODE_TOGGLE and MODE_LEVEL constants;
  - a lowest-set-bit priority function.
- One sub-module, irq_sync_edge: a single channel's synchroniser, previous-sample register, event and level outputs, and reset preload. It is instantiated NCHAN times via generate.

Test Plan:
- Post-reset preload: hold IRQ[2]=1 through reset, then release → PEND=0, O_REQ=0 for 10 cycles.
- Toggle request and acknowledge:
  - Setup: MASK=8'h07, I_IE=1, toggle IRQ[1].
  - Expect: O_REQ=1 three cycles later, O_VEC=16'h0004.
  - Then pulse I_ACK → PEND=0, ISR=8'h02, O_REQ=0.
- Nesting:
  - Setup: ISR=8'h02 (channel 1 in service). Toggle IRQ[0] and IRQ[2] together.
  - Expect: O_REQ with O_VEC=16'h0002 (channel 0 only).
  - Then ACK, EOI, EOI → ISR=0 and O_REQ for channel 2 with O_VEC=16'h0006.
- Overflow: toggle IRQ[3] twice while it is masked → PEND[3]=1, OVF[3]=1. A write of 8'h08 to OVF clears it.
- Level mode: MODE[4]=1, hold IRQ[4]=1, then ACK and EOI → O_REQ reasserts. Dropping IRQ[4] clears PEND[4] three cycles later.
- Precedence and reset: a W1C of PEND[5] in the same cycle as a new event leaves PEND[5]=1. Asserting RESET mid-ISR clears ISR to 0 and O_REQ to 0.
